// File: rtl/ysyx_24080006_axi_sram_if.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_axi_sram_if
// AXI4 bus bundle between a master (IFU/LSU side) and the SRAM responder.
//
// Handshake semantics, all five channels: a transfer happens on the rising
// clock edge where valid and ready are both 1. Once valid rises, the sender
// holds it and every payload signal stable until that edge. Valid never
// waits for ready, and ready may be raised before valid.
//
// Signals:
//   aw*  write address   (awvalid, awready, awaddr, awid, awlen, awsize, awburst)
//   w*   write data      (wvalid, wready, wdata, wstrb, wlast)
//   b*   write response  (bvalid, bready, bresp, bid)
//   ar*  read address    (arvalid, arready, araddr, arid, arlen, arsize, arburst)
//   r*   read data       (rvalid, rready, rdata, rresp, rlast, rid)
// Modports: master drives requests, slave drives responses.
// ---------------------------------------------------------------------------
interface ysyx_24080006_axi_sram_if #(
    parameter int ID_W = 4
);
    logic            awvalid;
    logic            awready;
    logic [31:0]     awaddr;
    logic [ID_W-1:0] awid;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;

    logic            wvalid;
    logic            wready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;

    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;

    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [ID_W-1:0] arid;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;

    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic [ID_W-1:0] rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_24080006_axi_sram.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_axi_sram
// AXI4 responder backed by a word-addressed register-array SRAM. The read and
// write channels each have their own FSM and run concurrently. INCR and WRAP
// bursts step the address by 4 per beat (WRAP is not wrapped), FIXED bursts
// reuse the start address. Low address bits are ignored.
//
// Ports:
//   clock        clock
//   reset        synchronous, active-high
//   bus          ysyx_24080006_axi_sram_if.slave (AW, W, B, AR, R channels)
//   dbg_r_state  read FSM state  (0 R_IDLE, 1 R_WAIT, 2 R_DATA)
//   dbg_w_state  write FSM state (0 W_IDLE, 1 W_DATA, 2 W_RESP)
// ---------------------------------------------------------------------------
module ysyx_24080006_axi_sram #(
    parameter int          DATA_W = 32,
    parameter int          ID_W   = 4,
    parameter int          DEPTH  = 1024,
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int          RD_LAT = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    ysyx_24080006_axi_sram_if.slave  bus,
    output logic [1:0]               dbg_r_state,
    output logic [1:0]               dbg_w_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH));
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE) >> 2);
    endfunction

    // Response codes are ordered so that the numerically larger one is worse.
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // ------------------------------------------------------------- read side
    r_state_t          r_state;
    logic [ID_W-1:0]   rid_q;
    logic [7:0]        r_len;
    logic [7:0]        r_beat;
    logic [1:0]        r_burst;
    logic              r_size_err;
    logic [31:0]       r_addr;
    logic [LW-1:0]     r_lat;
    logic              rvalid_q;
    logic              rlast_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    // Address/data of whichever beat would be loaded at the next edge.
    logic [31:0]       r_next_addr;
    logic [31:0]       ld_addr;
    logic              ld_size_err;
    logic              ld_ok;
    logic [DATA_W-1:0] ld_data;
    logic [1:0]        ld_resp;

    always_comb begin
        r_next_addr = (r_burst == BURST_FIXED) ? r_addr : r_addr + 32'd4;
        ld_addr     = r_next_addr;
        ld_size_err = r_size_err;
        case (r_state)
            R_IDLE: begin
                ld_addr     = bus.araddr;
                ld_size_err = (bus.arsize > 3'd2);
            end
            R_WAIT: begin
                ld_addr     = r_addr;
                ld_size_err = r_size_err;
            end
            default: begin
                ld_addr     = r_next_addr;
                ld_size_err = r_size_err;
            end
        endcase
        ld_ok   = in_range(ld_addr);
        ld_data = ld_ok ? mem[word_idx(ld_addr)] : '0;
        ld_resp = !ld_ok ? RESP_DECERR : (ld_size_err ? RESP_SLVERR : RESP_OKAY);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= R_IDLE;
            rid_q      <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_burst    <= '0;
            r_size_err <= 1'b0;
            r_addr     <= '0;
            r_lat      <= '0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (bus.arvalid) begin
                        rid_q      <= bus.arid;
                        r_len      <= bus.arlen;
                        r_burst    <= bus.arburst;
                        r_size_err <= (bus.arsize > 3'd2);
                        r_beat     <= '0;
                        r_addr     <= bus.araddr;
                        r_lat      <= LW'(RD_LAT - 1);
                        if (RD_LAT == 1) begin
                            r_state  <= R_DATA;
                            rvalid_q <= 1'b1;
                            rdata_q  <= ld_data;
                            rresp_q  <= ld_resp;
                            rlast_q  <= (bus.arlen == 8'd0);
                        end else begin
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    r_lat <= r_lat - LW'(1);
                    // Counter hits zero at this edge: first beat goes out now.
                    if (r_lat == LW'(1)) begin
                        r_state  <= R_DATA;
                        rvalid_q <= 1'b1;
                        rdata_q  <= ld_data;
                        rresp_q  <= ld_resp;
                        rlast_q  <= (r_len == 8'd0);
                    end
                end
                R_DATA: begin
                    if (bus.rready) begin
                        if (rlast_q) begin
                            r_state  <= R_IDLE;
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                        end else begin
                            // Next beat is loaded on the same edge for 1 beat/cycle.
                            r_beat  <= r_beat + 8'd1;
                            r_addr  <= r_next_addr;
                            rdata_q <= ld_data;
                            rresp_q <= ld_resp;
                            rlast_q <= ((r_beat + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ write side
    w_state_t        w_state;
    logic [ID_W-1:0] bid_q;
    logic [7:0]      w_len;
    logic [7:0]      w_beat;
    logic [1:0]      w_burst;
    logic            w_size_err;
    logic [31:0]     w_addr;
    logic [1:0]      w_err;
    logic            bvalid_q;
    logic [1:0]      bresp_q;

    logic            w_ok;
    logic            w_last_beat;
    logic [1:0]      w_beat_resp;
    logic [1:0]      w_proto_resp;
    logic [1:0]      w_err_next;
    logic [31:0]     w_next_addr;
    logic            mem_we;

    always_comb begin
        w_ok         = in_range(w_addr);
        w_last_beat  = (w_beat == w_len);
        w_beat_resp  = !w_ok ? RESP_DECERR : (w_size_err ? RESP_SLVERR : RESP_OKAY);
        w_proto_resp = (bus.wlast != w_last_beat) ? RESP_SLVERR : RESP_OKAY;
        w_err_next   = worst(w_err, worst(w_beat_resp, w_proto_resp));
        w_next_addr  = (w_burst == BURST_FIXED) ? w_addr : w_addr + 32'd4;
        // Out-of-range beats are dropped; reset aborts the beat at that edge.
        mem_we       = (w_state == W_DATA) && bus.wvalid && w_ok && !reset;
    end

    // Memory is never reset; writes use the old value for same-edge reads.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (bus.wstrb[i]) begin
                    mem[word_idx(w_addr)][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state    <= W_IDLE;
            bid_q      <= '0;
            w_len      <= '0;
            w_beat     <= '0;
            w_burst    <= '0;
            w_size_err <= 1'b0;
            w_addr     <= '0;
            w_err      <= RESP_OKAY;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (bus.awvalid) begin
                        bid_q      <= bus.awid;
                        w_len      <= bus.awlen;
                        w_burst    <= bus.awburst;
                        w_size_err <= (bus.awsize > 3'd2);
                        w_addr     <= bus.awaddr;
                        w_beat     <= '0;
                        w_err      <= RESP_OKAY;
                        w_state    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus.wvalid) begin
                        w_err <= w_err_next;
                        // The beat count, not wlast, decides where the burst ends.
                        if (w_last_beat) begin
                            w_state  <= W_RESP;
                            bvalid_q <= 1'b1;
                            bresp_q  <= w_err_next;
                        end else begin
                            w_beat <= w_beat + 8'd1;
                            w_addr <= w_next_addr;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        w_state  <= W_IDLE;
                        bvalid_q <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    assign bus.arready = (r_state == R_IDLE) && !reset;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = rid_q;

    assign bus.awready = (w_state == W_IDLE) && !reset;
    assign bus.wready  = (w_state == W_DATA) && !reset;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bid     = bid_q;

    assign dbg_r_state = r_state;
    assign dbg_w_state = w_state;
endmodule

// File: tb/tb_ysyx_24080006_axi_sram.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24080006_axi_sram
// Directed scenarios plus a randomized mix of read/write bursts, checked
// against a word-array memory model and per-beat address/response rules.
// ---------------------------------------------------------------------------
module tb_ysyx_24080006_axi_sram;
    localparam int          ID_W   = 4;
    localparam int          DEPTH  = 1024;
    localparam int          RD_LAT = 2;
    localparam int          TMO    = 200;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_24080006_axi_sram_if #(.ID_W(ID_W)) bus ();
    logic [1:0] dbg_r_state;
    logic [1:0] dbg_w_state;

    ysyx_24080006_axi_sram #(
        .DATA_W(32), .ID_W(ID_W), .DEPTH(DEPTH), .BASE(BASE), .RD_LAT(RD_LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .dbg_r_state(dbg_r_state),
        .dbg_w_state(dbg_w_state)
    );

    int errors = 0;
    int checks = 0;

    // Reference memory: only words 0..63 are ever read in range.
    logic [31:0] model_mem [DEPTH];

    logic [31:0] w_data_q [$];
    logic [3:0]  w_strb_q [$];
    logic        w_last_q [$];

    logic [31:0] exp_q [$];
    logic [31:0] r_data_q [$];
    logic [1:0]  r_resp_q [$];
    logic        r_last_q [$];
    logic [3:0]  r_id_q [$];
    int          r_lat_meas;

    // ------------------------------------------------------------- model
    function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [1:0] burst, input int b);
        return (burst == 2'b00) ? addr : addr + 32'(4 * b);
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 4) < DEPTH);
    endfunction

    function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic [2:0] size);
        if (!addr_ok(a)) return 2'b11;
        if (size > 3'd2) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return addr_ok(a) ? model_mem[(a - BASE) / 4] : 32'h0;
    endfunction

    // Applies the queued write beats to the model and returns the expected bresp.
    function automatic logic [1:0] model_apply_write(input logic [31:0] addr, input logic [1:0] burst,
                                                     input logic [2:0] size, input int len);
        logic [1:0]  resp;
        logic [1:0]  r;
        logic [31:0] a;
        logic [31:0] wd;
        resp = 2'b00;
        for (int b = 0; b <= len; b++) begin
            a = beat_addr(addr, burst, b);
            r = beat_resp(a, size);
            if (w_last_q[b] != (b == len) && r < 2'b10) r = 2'b10;
            if (r > resp) resp = r;
            if (addr_ok(a)) begin
                wd = model_mem[(a - BASE) / 4];
                for (int i = 0; i < 4; i++)
                    if (w_strb_q[b][i]) wd[8*i +: 8] = w_data_q[b][8*i +: 8];
                model_mem[(a - BASE) / 4] = wd;
            end
        end
        return resp;
    endfunction

    // ----------------------------------------------------------- drivers
    // All drivers start and end at 1 time unit after a rising edge.
    task automatic do_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
        logic hs = 1'b0;
        int   n  = 0;
        bus.awvalid = 1'b1; bus.awaddr = addr; bus.awid = id;
        bus.awlen = len; bus.awburst = burst; bus.awsize = size;
        while (!hs) begin
            hs = bus.awready;
            @(posedge clock); #1;
            if (!hs && ++n > TMO) begin
                checks++; errors++;
                $display("FAIL aw_timeout: no awready within %0d cycles", TMO);
                break;
            end
        end
        bus.awvalid = 1'b0;
    endtask

    task automatic do_w();
        logic hs;
        int   n;
        while (w_data_q.size() > 0) begin
            bus.wvalid = 1'b1;
            bus.wdata  = w_data_q.pop_front();
            bus.wstrb  = w_strb_q.pop_front();
            bus.wlast  = w_last_q.pop_front();
            hs = 1'b0; n = 0;
            while (!hs) begin
                hs = bus.wready;
                @(posedge clock); #1;
                if (!hs && ++n > TMO) begin
                    checks++; errors++;
                    $display("FAIL w_timeout: no wready within %0d cycles", TMO);
                    break;
                end
            end
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic do_b(output logic [1:0] resp, output logic [3:0] id);
        logic hs = 1'b0;
        int   n  = 0;
        resp = 2'bxx; id = 4'hx;
        bus.bready = 1'b1;
        while (!hs) begin
            hs = bus.bvalid; resp = bus.bresp; id = bus.bid;
            @(posedge clock); #1;
            if (!hs && ++n > TMO) begin
                checks++; errors++;
                $display("FAIL b_timeout: no bvalid within %0d cycles", TMO);
                break;
            end
        end
        bus.bready = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
        logic hs = 1'b0;
        int   n  = 0;
        bus.arvalid = 1'b1; bus.araddr = addr; bus.arid = id;
        bus.arlen = len; bus.arburst = burst; bus.arsize = size;
        while (!hs) begin
            hs = bus.arready;
            @(posedge clock); #1;
            if (!hs && ++n > TMO) begin
                checks++; errors++;
                $display("FAIL ar_timeout: no arready within %0d cycles", TMO);
                break;
            end
        end
        bus.arvalid = 1'b0;
    endtask

    // mode 0: rready held high, 1: toggled 1,0,1,0..., 2: random.
    task automatic r_collect(input int len, input int mode);
        int          got  = 0;
        int          cyc  = 0;
        int          lat  = 1;
        bit          seen = 1'b0;
        logic        rr, v, l;
        logic [31:0] d;
        logic [1:0]  rs;
        r_data_q.delete(); r_resp_q.delete(); r_last_q.delete(); r_id_q.delete();
        while (got < len + 1) begin
            if (!seen && bus.rvalid) seen = 1'b1;
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            bus.rready = rr;
            v = bus.rvalid; d = bus.rdata; rs = bus.rresp; l = bus.rlast;
            if (v && rr) begin
                r_data_q.push_back(d); r_resp_q.push_back(rs);
                r_last_q.push_back(l); r_id_q.push_back(bus.rid);
            end
            checks++;
            if (bus.arready !== 1'b0) begin
                errors++;
                $display("FAIL arready_busy: got %b want 0 during burst", bus.arready);
            end
            @(posedge clock); #1;
            cyc++;
            if (v && rr) got++;
            else if (v) begin
                checks++;
                if (bus.rdata !== d || bus.rresp !== rs || bus.rlast !== l) begin
                    errors++;
                    $display("FAIL stall_hold: got %h/%b/%b want %h/%b/%b",
                             bus.rdata, bus.rresp, bus.rlast, d, rs, l);
                end
            end
            if (!seen) lat++;
            if (cyc > TMO * (len + 1)) begin
                checks++; errors++;
                $display("FAIL r_timeout: %0d of %0d beats", got, len + 1);
                break;
            end
        end
        bus.rready = 1'b0;
        r_lat_meas = lat;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int mode);
        do_ar(addr, id, len, burst, size);
        r_collect(int'(len), mode);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size,
                             output logic [1:0] resp, output logic [3:0] bid);
        do_aw(addr, id, len, burst, size);
        do_w();
        do_b(resp, bid);
    endtask

    task automatic queue_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        w_data_q.push_back(d); w_strb_q.push_back(s); w_last_q.push_back(l);
    endtask

    // Compares collected beats against exp_q and per-beat response rules.
    task automatic check_read(input string name, input logic [31:0] addr, input logic [3:0] id,
                              input int len, input logic [1:0] burst, input logic [2:0] size);
        for (int b = 0; b <= len; b++) begin
            if (b >= r_data_q.size()) break;
            checks++;
            if (r_data_q[b] !== exp_q[b]) begin
                errors++;
                $display("FAIL %s_data[%0d]: got %h want %h", name, b, r_data_q[b], exp_q[b]);
            end
            checks++;
            if (r_resp_q[b] !== beat_resp(beat_addr(addr, burst, b), size)) begin
                errors++;
                $display("FAIL %s_resp[%0d]: got %b want %b", name, b, r_resp_q[b],
                         beat_resp(beat_addr(addr, burst, b), size));
            end
            checks++;
            if (r_last_q[b] !== (b == len) || r_id_q[b] !== id) begin
                errors++;
                $display("FAIL %s_last_id[%0d]: got %b/%h want %b/%h", name, b,
                         r_last_q[b], r_id_q[b], (b == len), id);
            end
        end
    endtask

    task automatic load_exp(input logic [31:0] addr, input int len, input logic [1:0] burst);
        exp_q.delete();
        for (int b = 0; b <= len; b++) exp_q.push_back(model_read(beat_addr(addr, burst, b)));
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        logic [31:0] outs;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        outs = {bus.rvalid, bus.bvalid, bus.wready, bus.rlast, bus.arready, bus.awready,
                bus.rresp, bus.bresp, 22'h0};
        checks++;
        if (outs !== 32'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got %h want 00000000", outs);
        end
        checks++;
        if (bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 00000000", bus.rdata);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (bus.arready !== 1'b1 || bus.awready !== 1'b1 || bus.wready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ar=%b aw=%b w=%b want 1 1 0",
                     bus.arready, bus.awready, bus.wready);
        end
    endtask

    task automatic test_preload();
        logic [1:0] resp, er;
        logic [3:0] id;
        for (int i = 0; i < 64; i++) queue_beat($urandom, 4'hf, i == 63);
        er = model_apply_write(BASE, 2'b01, 3'd2, 63);
        axi_write(BASE, 4'h9, 8'd63, 2'b01, 3'd2, resp, id);
        checks++;
        if (resp !== er || id !== 4'h9) begin
            errors++;
            $display("FAIL preload_b: got %b/%h want %b/9", resp, id, er);
        end
    endtask

    task automatic test_single_read();
        logic [1:0] resp;
        logic [3:0] id;
        queue_beat(32'hDEAD_BEEF, 4'hf, 1'b1);
        void'(model_apply_write(BASE, 2'b01, 3'd2, 0));
        axi_write(BASE, 4'h1, 8'd0, 2'b01, 3'd2, resp, id);
        axi_read(BASE, 4'h3, 8'd0, 2'b01, 3'd2, 0);
        exp_q.delete(); exp_q.push_back(32'hDEAD_BEEF);
        check_read("single", BASE, 4'h3, 0, 2'b01, 3'd2);
        checks++;
        if (r_lat_meas != RD_LAT) begin
            errors++;
            $display("FAIL single_latency: got %0d want %0d", r_lat_meas, RD_LAT);
        end
    endtask

    task automatic test_incr_read();
        load_exp(BASE + 32'h10, 3, 2'b01);
        axi_read(BASE + 32'h10, 4'h7, 8'd3, 2'b01, 3'd2, 1);
        checks++;
        if (r_data_q.size() != 4) begin
            errors++;
            $display("FAIL incr_count: got %0d want 4", r_data_q.size());
        end
        check_read("incr", BASE + 32'h10, 4'h7, 3, 2'b01, 3'd2);
    endtask

    task automatic test_strobed_write();
        logic [1:0] resp;
        logic [3:0] id;
        queue_beat(32'h0, 4'hf, 1'b1);
        void'(model_apply_write(BASE + 4, 2'b01, 3'd2, 0));
        axi_write(BASE + 4, 4'h2, 8'd0, 2'b01, 3'd2, resp, id);
        queue_beat(32'h1122_3344, 4'b0101, 1'b1);
        void'(model_apply_write(BASE + 4, 2'b01, 3'd2, 0));
        axi_write(BASE + 4, 4'h5, 8'd0, 2'b01, 3'd2, resp, id);
        checks++;
        if (resp !== 2'b00 || id !== 4'h5) begin
            errors++;
            $display("FAIL strobe_b: got %b/%h want 00/5", resp, id);
        end
        axi_read(BASE + 4, 4'h0, 8'd0, 2'b01, 3'd2, 0);
        exp_q.delete(); exp_q.push_back(32'h0022_0044);
        check_read("strobe_rd", BASE + 4, 4'h0, 0, 2'b01, 3'd2);
    endtask

    task automatic test_out_of_range();
        logic [1:0]  resp;
        logic [3:0]  id;
        logic [31:0] top;
        top = BASE + 32'(4 * DEPTH);
        axi_read(32'h7FFF_FFFC, 4'h8, 8'd1, 2'b00, 3'd2, 0);
        exp_q.delete(); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        check_read("oor_rd", 32'h7FFF_FFFC, 4'h8, 1, 2'b00, 3'd2);
        queue_beat(32'hA5A5_5A5A, 4'hf, 1'b1);
        void'(model_apply_write(top, 2'b01, 3'd2, 0));
        axi_write(top, 4'h2, 8'd0, 2'b01, 3'd2, resp, id);
        checks++;
        if (resp !== 2'b11 || id !== 4'h2) begin
            errors++;
            $display("FAIL oor_b: got %b/%h want 11/2", resp, id);
        end
        load_exp(BASE, 1, 2'b01);
        axi_read(BASE, 4'h1, 8'd1, 2'b01, 3'd2, 0);
        check_read("oor_nochange", BASE, 4'h1, 1, 2'b01, 3'd2);
    endtask

    task automatic test_wlast_mismatch();
        logic [1:0] resp;
        logic [3:0] id;
        queue_beat(32'h1357_9BDF, 4'hf, 1'b1);
        queue_beat(32'h2468_ACE0, 4'hf, 1'b0);
        void'(model_apply_write(BASE + 32'h20, 2'b01, 3'd2, 1));
        axi_write(BASE + 32'h20, 4'hA, 8'd1, 2'b01, 3'd2, resp, id);
        checks++;
        if (resp !== 2'b10 || id !== 4'hA) begin
            errors++;
            $display("FAIL wlast_b: got %b/%h want 10/a", resp, id);
        end
        exp_q.delete(); exp_q.push_back(32'h1357_9BDF); exp_q.push_back(32'h2468_ACE0);
        axi_read(BASE + 32'h20, 4'h4, 8'd1, 2'b01, 3'd2, 0);
        check_read("wlast_rd", BASE + 32'h20, 4'h4, 1, 2'b01, 3'd2);
    endtask

    task automatic test_concurrent();
        logic [1:0]  resp;
        logic [3:0]  id;
        logic [31:0] nv;
        nv = 32'hC0FF_EE00 ^ $urandom_range(0, 255);
        load_exp(BASE, 0, 2'b01);
        do_aw(BASE, 4'h1, 8'd0, 2'b01, 3'd2);
        bus.wdata = nv; bus.wstrb = 4'hf; bus.wlast = 1'b1;
        bus.arvalid = 1'b1; bus.araddr = BASE; bus.arid = 4'h4;
        bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arsize = 3'd2;
        // Line the W handshake up with the edge that loads the first read beat.
        if (RD_LAT == 1) bus.wvalid = 1'b1;
        @(posedge clock); #1;
        bus.arvalid = 1'b0;
        if (RD_LAT == 1) begin
            bus.wvalid = 1'b0;
        end else begin
            for (int i = 0; i < RD_LAT - 2; i++) begin
                @(posedge clock); #1;
            end
            bus.wvalid = 1'b1;
            @(posedge clock); #1;
            bus.wvalid = 1'b0;
        end
        bus.wlast = 1'b0;
        r_collect(0, 0);
        check_read("rbw_old", BASE, 4'h4, 0, 2'b01, 3'd2);
        do_b(resp, id);
        checks++;
        if (resp !== 2'b00 || id !== 4'h1) begin
            errors++;
            $display("FAIL rbw_b: got %b/%h want 00/1", resp, id);
        end
        model_mem[0] = nv;
        load_exp(BASE, 0, 2'b01);
        axi_read(BASE, 4'h5, 8'd0, 2'b01, 3'd2, 0);
        check_read("rbw_new", BASE, 4'h5, 0, 2'b01, 3'd2);
    endtask

    task automatic test_mid_reset();
        int n = 0;
        do_ar(BASE + 32'h10, 4'h6, 8'd3, 2'b01, 3'd2);
        bus.rready = 1'b0;
        while (!bus.rvalid && n < TMO) begin
            @(posedge clock); #1;
            n++;
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.arready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: got rvalid=%b rlast=%b arready=%b want 0 0 0",
                     bus.rvalid, bus.rlast, bus.arready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.arready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_arready: got %b want 1", bus.arready);
        end
        bus.rready = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_quiet: got rvalid=%b arready=%b want 0 1", bus.rvalid, bus.arready);
        end
        bus.rready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst, resp, er;
        logic [2:0]  size;
        logic [3:0]  id, bid;
        for (int t = 0; t < 60; t++) begin
            len   = 8'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 2));
            size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'd2;
            id    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1)
                    addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100));
                else
                    addr = BASE - 32'(4 * (int'(len) + 1)) - 32'(4 * $urandom_range(0, 10));
            end else begin
                addr = BASE + 32'(4 * $urandom_range(0, 63 - int'(len))) + 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b <= int'(len); b++)
                    queue_beat($urandom, 4'($urandom_range(0, 15)),
                               ($urandom_range(0, 7) == 0) ? (b != int'(len)) : (b == int'(len)));
                er = model_apply_write(addr, burst, size, int'(len));
                axi_write(addr, id, len, burst, size, resp, bid);
                checks++;
                if (resp !== er || bid !== id) begin
                    errors++;
                    $display("FAIL rand_b[%0d]: got %b/%h want %b/%h", t, resp, bid, er, id);
                end
            end else begin
                load_exp(addr, int'(len), burst);
                axi_read(addr, id, len, burst, size, 2);
                check_read("rand_rd", addr, id, int'(len), burst, size);
            end
        end
    endtask

    initial begin
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0;
        bus.awsize = '0; bus.awburst = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
        bus.arsize = '0; bus.arburst = '0;
        bus.rready = 1'b0;

        test_reset();
        test_preload();
        test_single_read();
        test_incr_read();
        test_strobed_write();
        test_out_of_range();
        test_wlast_mismatch();
        test_concurrent();
        test_mid_reset();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
